// File: rtl/alu_ft.sv
// alu_ft: time-redundant fault-tolerant ALU.
// A combinational core ALU is evaluated on two consecutive clock edges
// with the same operands. When both runs agree, the result is published.
// When they disagree, a third run is taken and the outputs are a bitwise
// majority vote of the three.
// Build option: define ALU_FT_STICKY_FAULT_EN to make fault_detected_out
// stay set until reset instead of tracking only the latest sequence.

module alu_ft_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [WIDTH:0]   sum_ext;
  logic        [WIDTH:0]   diff_ext;
  logic                    add_ovf;
  logic                    sub_ovf;

  assign a_s = $signed(A);
  assign b_s = $signed(B);

  // Subtraction as A + ~B + 1, so the extra top bit is the no-borrow flag.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  // Overflow when operand signs make the true result unrepresentable.
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1]  != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);

  // Operation decode; flags only meaningful for ADD and SUB.
  always_comb begin
    Result   = '0;
    Carry    = 1'b0;
    OverFlow = 1'b0;
    case (ALUControl)
      3'b000: Result = A & B;
      3'b001: Result = A | B;
      3'b010: begin
        Result   = sum_ext[WIDTH-1:0];
        Carry    = sum_ext[WIDTH];
        OverFlow = add_ovf;
      end
      3'b011: Result = A ^ B;
      3'b100: Result = ~(A | B);
      3'b101: Result = {{(WIDTH-1){1'b0}}, (A < B)};
      3'b110: begin
        Result   = diff_ext[WIDTH-1:0];
        Carry    = diff_ext[WIDTH];
        OverFlow = sub_ovf;
      end
      3'b111: Result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: Result = '0;
    endcase
  end

endmodule

module alu_ft #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Negative,
  output logic             fault_detected_out
);

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;

  logic [1:0]       state_q, state_d;

  // Captured runs; names kept stable for external probing.
  logic [WIDTH-1:0] res_t1, res_t2, res_t3;
  logic             res_t1_c, res_t2_c, res_t3_c;
  logic             res_t1_v, res_t2_v, res_t3_v;
  logic [WIDTH-1:0] res_t1_d, res_t2_d, res_t3_d;
  logic             res_t1_c_d, res_t2_c_d, res_t3_c_d;
  logic             res_t1_v_d, res_t2_v_d, res_t3_v_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic             core_v;
  logic [WIDTH-1:0] voted;
  logic             runs_match;

  alu_ft_core #(.WIDTH(WIDTH)) u_alu (
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .Result     (core_res),
    .Carry      (core_c),
    .OverFlow   (core_v)
  );

  function automatic logic [WIDTH-1:0] maj_vec(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic maj_bit(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign runs_match = (core_res == res_t1) && (core_c == res_t1_c) && (core_v == res_t1_v);

  // Sequence control: capture run 1, compare run 2, vote with run 3 on mismatch.
  always_comb begin
    state_d    = state_q;
    res_t1_d   = res_t1;
    res_t1_c_d = res_t1_c;
    res_t1_v_d = res_t1_v;
    res_t2_d   = res_t2;
    res_t2_c_d = res_t2_c;
    res_t2_v_d = res_t2_v;
    res_t3_d   = res_t3;
    res_t3_c_d = res_t3_c;
    res_t3_v_d = res_t3_v;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    fault_d    = fault_q;
    voted      = '0;
    case (state_q)
      T1: begin
        res_t1_d   = core_res;
        res_t1_c_d = core_c;
        res_t1_v_d = core_v;
        state_d    = T2;
      end
      T2: begin
        res_t2_d   = core_res;
        res_t2_c_d = core_c;
        res_t2_v_d = core_v;
        if (runs_match) begin
          result_d = core_res;
          carry_d  = core_c;
          ovf_d    = core_v;
          zero_d   = (core_res == '0);
          neg_d    = core_res[WIDTH-1];
`ifdef ALU_FT_STICKY_FAULT_EN
          fault_d  = fault_q;
`else
          fault_d  = 1'b0;
`endif
          state_d  = T1;
        end else begin
          state_d  = T3;
        end
      end
      T3: begin
        res_t3_d   = core_res;
        res_t3_c_d = core_c;
        res_t3_v_d = core_v;
        // Vote on this edge's core output directly; it is what res_t3 captures.
        voted      = maj_vec(res_t1, res_t2, core_res);
        result_d   = voted;
        carry_d    = maj_bit(res_t1_c, res_t2_c, core_c);
        ovf_d      = maj_bit(res_t1_v, res_t2_v, core_v);
        zero_d     = (voted == '0);
        neg_d      = voted[WIDTH-1];
        fault_d    = 1'b1;
        state_d    = T1;
      end
      default: state_d = T1;
    endcase
  end

  // State and output registers; reset discards any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T1;
      res_t1   <= '0;
      res_t1_c <= 1'b0;
      res_t1_v <= 1'b0;
      res_t2   <= '0;
      res_t2_c <= 1'b0;
      res_t2_v <= 1'b0;
      res_t3   <= '0;
      res_t3_c <= 1'b0;
      res_t3_v <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_t1   <= res_t1_d;
      res_t1_c <= res_t1_c_d;
      res_t1_v <= res_t1_v_d;
      res_t2   <= res_t2_d;
      res_t2_c <= res_t2_c_d;
      res_t2_v <= res_t2_v_d;
      res_t3   <= res_t3_d;
      res_t3_c <= res_t3_c_d;
      res_t3_v <= res_t3_v_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      fault_q  <= fault_d;
    end
  end

  assign Result             = result_q;
  assign Zero               = zero_q;
  assign Carry              = carry_q;
  assign OverFlow           = ovf_q;
  assign Negative           = neg_q;
  assign fault_detected_out = fault_q;

endmodule

// File: tb/tb_alu_ft.sv
// Self-checking bench for alu_ft (WIDTH=32): sequence-level reference model
// compared every cycle, plus literal expectations for the documented cases.

module tb_alu_ft;

  localparam int W = 32;
  localparam logic [W-1:0] FORCE_VAL = ~32'h0000019F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] Result;
  logic         Zero, Carry, OverFlow, Negative, fault;

  alu_ft #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .A                  (A),
    .B                  (B),
    .ALUControl         (op),
    .Result             (Result),
    .Zero               (Zero),
    .Carry              (Carry),
    .OverFlow           (OverFlow),
    .Negative           (Negative),
    .fault_detected_out (fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] m_res = '0;
  bit m_z = 0, m_c = 0, m_v = 0, m_n = 0, m_f = 0;
  int run_idx = 0;
  logic [W-1:0] run_r [3];
  bit run_c [3];
  bit run_v [3];
  bit force_active = 0;
  bit mdl_on = 0;
  logic [W-1:0] mr, vr;
  bit mc, mv;

  // Plain-integer definition of every operation.
  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] o, output logic [W-1:0] r,
                                  output bit c, output bit v);
    longint unsigned ua, ub, s;
    longint sa, sb, ss;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0;
    v = 0;
    case (o)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = ua + ub; r = s[W-1:0];
        c = (s > 64'h0000_0000_FFFF_FFFF);
        ss = sa + sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'b011: r = a ^ b;
      3'b100: r = ~(a | b);
      3'b101: r = (ua < ub) ? 32'd1 : 32'd0;
      3'b110: begin
        s = ua - ub; r = s[W-1:0];
        c = (ua >= ub);
        ss = sa - sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] vote3(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    logic [W-1:0] o;
    for (int i = 0; i < W; i++) o[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
    return o;
  endfunction

  task automatic publish(input logic [W-1:0] r, input bit c, input bit v, input bit f);
    m_res = r;
    m_z = (r == 0);
    m_n = r[W-1];
    m_c = c;
    m_v = v;
`ifdef ALU_FT_STICKY_FAULT_EN
    m_f = m_f | f;
`else
    m_f = f;
`endif
  endtask

  // Model: each sequence evaluates the operation up to three times; two
  // equal runs publish, otherwise the three runs are voted.
  always @(posedge clk) begin
    if (rst) begin
      run_idx = 0;
      m_res = '0; m_z = 0; m_c = 0; m_v = 0; m_n = 0; m_f = 0;
    end else begin
      ref_alu(A, B, op, mr, mc, mv);
      if (force_active) mr = FORCE_VAL;
      run_r[run_idx] = mr; run_c[run_idx] = mc; run_v[run_idx] = mv;
      if (run_idx == 0) run_idx = 1;
      else if (run_idx == 1) begin
        if (run_r[0] == run_r[1] && run_c[0] == run_c[1] && run_v[0] == run_v[1]) begin
          publish(run_r[1], run_c[1], run_v[1], 1'b0);
          run_idx = 0;
        end else run_idx = 2;
      end else begin
        vr = vote3(run_r[0], run_r[1], run_r[2]);
        publish(vr, (int'(run_c[0]) + int'(run_c[1]) + int'(run_c[2])) >= 2,
                (int'(run_v[0]) + int'(run_v[1]) + int'(run_v[2])) >= 2, 1'b1);
        run_idx = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mdl_on) begin
      total++;
      if ({Result, Zero, Carry, OverFlow, Negative, fault} !== {m_res, m_z, m_c, m_v, m_n, m_f}) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got res=%h z=%0b c=%0b v=%0b n=%0b f=%0b want res=%h z=%0b c=%0b v=%0b n=%0b f=%0b",
                 $time, Result, Zero, Carry, OverFlow, Negative, fault, m_res, m_z, m_c, m_v, m_n, m_f);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called just after an edge that ends a sequence; runs one clean sequence.
  task automatic seq2(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
    A = a; B = b; op = o;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] saved_a, mask;

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    mdl_on = 1;
    chk("rst_result", {32'd0, Result}, 64'd0);
    chk("rst_flags", {58'd0, Zero, Carry, OverFlow, Negative, fault, 1'b0}, 64'd0);
    chk("rst_res_t1", {32'd0, dut.res_t1}, 64'd0);

    // Clean ADD after reset: result after the second edge.
    A = 32'hF5; B = 32'hAA; op = 3'b010;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("add_result", {32'd0, Result}, 64'h19F);
    chk("add_res_t1", {32'd0, dut.res_t1}, 64'h19F);
    chk("add_res_t2", {32'd0, dut.res_t2}, 64'h19F);
    chk("add_fault", {63'd0, fault}, 64'd0);
    chk("add_zero", {63'd0, Zero}, 64'd0);

    // Corrupt core result during run 2 only.
    @(posedge clk); #1;
    force dut.u_alu.Result = ~32'h0000019F;
    force_active = 1;
    @(posedge clk); #1;
    release dut.u_alu.Result;
    force_active = 0;
    chk("mismatch_hold", {32'd0, Result}, 64'h19F);
    chk("mismatch_hold_fault", {63'd0, fault}, 64'd0);
    @(posedge clk); #1;
    chk("vote_result", {32'd0, Result}, 64'h19F);
    chk("vote_fault", {63'd0, fault}, 64'd1);
    chk("vote_res_t2", {32'd0, dut.res_t2}, {32'd0, FORCE_VAL});

    // Clean sequence after a faulty one.
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef ALU_FT_STICKY_FAULT_EN
    chk("fault_after_clean", {63'd0, fault}, 64'd1);
`else
    chk("fault_after_clean", {63'd0, fault}, 64'd0);
`endif

    seq2(32'd5, 32'd5, 3'b110);
    chk("sub_eq_result", {32'd0, Result}, 64'd0);
    chk("sub_eq_flags", {60'd0, Zero, Carry, OverFlow, Negative}, 64'b1100);

    seq2(32'h7FFF_FFFF, 32'd1, 3'b010);
    chk("add_ovf_result", {32'd0, Result}, 64'h8000_0000);
    chk("add_ovf_flags", {60'd0, Zero, Carry, OverFlow, Negative}, 64'b0011);

    seq2(32'hFFFF_FFFF, 32'd1, 3'b111);
    chk("slt_result", {32'd0, Result}, 64'd1);
    seq2(32'hFFFF_FFFF, 32'd1, 3'b101);
    chk("sltu_result", {32'd0, Result}, 64'd0);

    // Reset while waiting for the third run.
    seq2(32'h7FFF_FFFF, 32'd1, 3'b010);
    A = 32'hF5; B = 32'hAA; op = 3'b010;
    @(posedge clk); #1;
    force dut.u_alu.Result = ~32'h0000019F;
    force_active = 1;
    @(posedge clk); #1;
    release dut.u_alu.Result;
    force_active = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_t3_result", {32'd0, Result}, 64'd0);
    chk("rst_t3_flags", {59'd0, Zero, Carry, OverFlow, Negative, fault}, 64'd0);
    chk("rst_t3_res_t2", {32'd0, dut.res_t2}, 64'd0);
    rst = 1'b0;

    // Reset while waiting for the second run.
    seq2(32'hF5, 32'hAA, 3'b010);
    A = 32'd1; B = 32'd2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_t2_result", {32'd0, Result}, 64'd0);
    chk("rst_t2_res_t1", {32'd0, dut.res_t1}, 64'd0);
    rst = 1'b0;

    // Randomized sequences, some with a transient operand disturbance on run 2.
    for (int n = 0; n < 300; n++) begin
      A = pick(); B = pick(); op = 3'($urandom_range(0, 7));
      saved_a = A;
      @(posedge clk); #1;
      if ($urandom_range(0, 5) == 0) begin
        mask = $urandom | 32'd1;
        A = saved_a ^ mask;
      end
      @(posedge clk); #1;
      A = saved_a;
      if (run_idx != 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ft.md
ALU_FT -- requirements
Module: alu_ft

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  WIDTH  operand A, held stable by the user for a whole sequence.
REQ-005 B  input  WIDTH  operand B, held stable by the user for a whole sequence.
REQ-006 ALUControl  input  3  operation select.
REQ-007 Result  output  WIDTH  registered, fault-tolerant result.
REQ-008 Zero  output  1  registered; Result == 0.
REQ-009 Carry  output  1  registered carry flag.
REQ-010 OverFlow  output  1  registered signed-overflow flag.
REQ-011 Negative  output  1  registered; Result[WIDTH-1].
REQ-012 fault_detected_out  output  1  registered; run mismatch seen in the last sequence.

Function
REQ-013 Combinational core ALU on live A/B/ALUControl: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU (zero-extended 1/0), 110 SUB (A-B), 111 SLT (signed, zero-extended 1/0).
REQ-014 Core Carry: ADD = carry-out of bit WIDTH-1; SUB = no-borrow (1 when A >= B unsigned); 0 for all other ops.
REQ-015 Core OverFlow: signed two's-complement overflow for ADD/SUB only, else 0; results wrap modulo 2^WIDTH.
REQ-016 FSM states T1, T2, T3; T1 is the reset state.
REQ-017 T1: on the edge, latch core result+Carry+OverFlow into res_t1 set; go to T2.
REQ-018 T2: on the edge, latch core outputs into res_t2 set; compare against res_t1 set (result, Carry, OverFlow).
REQ-019 T2 match: same edge, load Result/Carry/OverFlow from core, Zero/Negative derived from that result, fault_detected_out <= 0; go to T1.
REQ-020 T2 mismatch: outputs unchanged; go to T3.
REQ-021 T3: on the edge, latch core outputs into res_t3; Result <= bitwise majority(res_t1, res_t2, res_t3); Carry/OverFlow <= majority of the three captured flags; Zero/Negative derived from voted Result; fault_detected_out <= 1; go to T1.
REQ-022 Latency: 2 clocks from sequence start when runs agree, 3 clocks on mismatch; sequences run back-to-back continuously.
REQ-023 Outputs hold their last value between update edges; no valid/handshake signal; inputs changing mid-sequence yield an undefined but deterministic result (no protection).
REQ-024 Internal run registers named res_t1, res_t2, res_t3 and core instance named u_alu with output Result, for bench probing/forcing.

Reset
REQ-025 rst high at an edge: state <= T1; res_t1/res_t2/res_t3 <= 0; Result <= 0; Zero <= 0; Carry, OverFlow, Negative, fault_detected_out <= 0.
REQ-026 Reset dominates all transitions, including mid-sequence in T2/T3; the interrupted sequence is discarded without updating outputs.
REQ-027 First sequence starts on the first edge with rst low.

Configuration
REQ-028 Macro ALU_FT_STICKY_FAULT_EN defined: fault_detected_out, once set, stays 1 until reset; clean T2 matches do not clear it.
REQ-029 Macro undefined: fault_detected_out reflects only the most recent completed sequence (REQ-019/REQ-021).

Verification
REQ-030 Reset, then A=0xF5, B=0xAA, ADD, no fault -> after 2nd edge res_t1=res_t2=0x19F, Result=0x19F (415), fault_detected_out=0, Zero=0.
REQ-031 Same inputs, force u_alu.Result inverted during run 2 only -> mismatch, T3 entered, after 3rd edge Result=0x19F, fault_detected_out=1.
REQ-032 SUB A=5, B=5 -> Result=0, Zero=1, Carry=1, OverFlow=0; ADD A=0x7FFFFFFF, B=1 -> Result=0x80000000, OverFlow=1, Negative=1, Carry=0.
REQ-033 SLT A=0xFFFFFFFF, B=1 -> Result=1; SLTU same operands -> Result=0.
REQ-034 Assert rst while in T2 or T3 -> next state T1, all outputs 0, no vote performed.
REQ-035 Faulty sequence then clean sequence -> fault_detected_out stays 1 with ALU_FT_STICKY_FAULT_EN, returns to 0 without it.
